// File: rtl/wide_add_pkg.sv
// wide_add_pkg
// Shared definitions for the wide_add_sequencer slice:
//   LIMB_W           - width of one adder limb (the width of carry_select_adder)
//   wide_add_state_t - sequencer FSM state encoding (IDLE, RUN, DONE)
package wide_add_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wide_add_state_t;

endpackage

// File: rtl/wide_add_sequencer_carry_select_adder.sv
// carry_select_adder
// Purely combinational LIMB_W-bit adder. The upper half is computed for both
// possible carries from the lower half and the real one selects the result.
// Ports:
//   A, B  in  LIMB_W  addends
//   cin   in  1       carry in
//   S     out LIMB_W  sum
//   cout  out 1       carry out
module carry_select_adder
    import wide_add_pkg::*;
(
    input  logic [LIMB_W-1:0] A,
    input  logic [LIMB_W-1:0] B,
    input  logic              cin,
    output logic [LIMB_W-1:0] S,
    output logic              cout
);

    localparam int H = LIMB_W / 2;

    logic [H:0] w_lo;
    logic [H:0] w_hi0;
    logic [H:0] w_hi1;
    logic [H:0] w_hi;

    assign w_lo  = {1'b0, A[H-1:0]} + {1'b0, B[H-1:0]} + {{H{1'b0}}, cin};
    assign w_hi0 = {1'b0, A[LIMB_W-1:H]} + {1'b0, B[LIMB_W-1:H]};
    assign w_hi1 = {1'b0, A[LIMB_W-1:H]} + {1'b0, B[LIMB_W-1:H]} + {{H{1'b0}}, 1'b1};

    // Both upper-half sums are ready in parallel with the lower half; the
    // lower carry only drives a mux.
    assign w_hi = w_lo[H] ? w_hi1 : w_hi0;
    assign S    = {w_hi[H-1:0], w_lo[H-1:0]};
    assign cout = w_hi[H];

endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
// Adds two 16*WORDS-bit operands by stepping a single 16-bit
// carry_select_adder over the limbs, least-significant first, with the carry
// held in a register between limbs.
// Optional feature macro: WIDE_ADD_SUB_EN adds the in_sub port (A - B).
// Ports:
//   clk        in   1         clock, rising edge
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         operation offered
//   in_ready   out  1         idle, can accept (state decode only)
//   in_a/in_b  in   16*WORDS  operands
//   in_cin     in   1         carry into limb 0
//   in_sub     in   1         subtract select (WIDE_ADD_SUB_EN only)
//   out_valid  out  1         result held (state decode only)
//   out_ready  in   1         consumer takes the result
//   out_sum    out  16*WORDS  result
//   out_cout   out  1         carry out of the top limb
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LIMB_W*WORDS-1:0] in_a,
    input  logic [LIMB_W*WORDS-1:0] in_b,
    input  logic                    in_cin,
`ifdef WIDE_ADD_SUB_EN
    input  logic                    in_sub,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LIMB_W*WORDS-1:0] out_sum,
    output logic                    out_cout
);

    localparam int                IDX_W    = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    wide_add_state_t                r_state;
    logic [WORDS-1:0][LIMB_W-1:0]   r_a;
    logic [WORDS-1:0][LIMB_W-1:0]   r_b;
    logic [WORDS-1:0][LIMB_W-1:0]   r_sum;
    logic                           r_cout;
    logic                           r_carry;
    logic [IDX_W-1:0]               r_idx;
`ifdef WIDE_ADD_SUB_EN
    logic                           r_sub;
`endif

    logic [LIMB_W-1:0] w_a_limb;
    logic [LIMB_W-1:0] w_b_limb;
    logic [LIMB_W-1:0] w_s_limb;
    logic              w_cout;
    logic              w_cin_init;

    assign w_a_limb = r_a[r_idx];
`ifdef WIDE_ADD_SUB_EN
    // Two's-complement subtract: invert B limbs and seed the carry with 1.
    assign w_b_limb   = r_b[r_idx] ^ {LIMB_W{r_sub}};
    assign w_cin_init = in_sub ? 1'b1 : in_cin;
`else
    assign w_b_limb   = r_b[r_idx];
    assign w_cin_init = in_cin;
`endif

    carry_select_adder u_adder (
        .A    (w_a_limb),
        .B    (w_b_limb),
        .cin  (r_carry),
        .S    (w_s_limb),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
`ifdef WIDE_ADD_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    // in_ready is high throughout IDLE, so in_valid alone
                    // completes the handshake.
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= w_cin_init;
                        r_idx   <= '0;
`ifdef WIDE_ADD_SUB_EN
                        r_sub   <= in_sub;
`endif
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_idx] <= w_s_limb;
                    r_carry      <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        // Index parks on the top limb rather than wrapping.
                        r_cout  <= w_cout;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Handshake outputs depend on state only.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;

endmodule
